// File: rtl/mux_nto1_pipe.sv
// Pipelined NUM_IN-to-1 word multiplexer with valid/ready on both sides and a two-entry skid buffer.
// Optional out-of-range select detection is enabled by defining MUXN_RANGE_CHECK_EN.
module mux_nto1_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_TWO
    } state_e;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             err;
    } entry_t;

    state_e state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    entry_t cap;
    logic   in_ready_q;
    logic   out_valid_q;
    logic   in_xfer;
    logic   out_xfer;

    // Word selection; unmatched selects fall back to word 0.
    always_comb begin
        cap.data = in_data[WIDTH-1:0];
        cap.sel  = in_sel;
        cap.err  = 1'b0;
        for (int i = 1; i < NUM_IN; i++) begin
            if (in_sel == SEL_W'(i)) begin
                cap.data = in_data[i*WIDTH +: WIDTH];
            end
        end
`ifdef MUXN_RANGE_CHECK_EN
        if (32'(in_sel) >= NUM_IN) begin
            cap.data = '0;
            cap.err  = 1'b1;
        end
`endif
    end

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    main_d  = cap;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_xfer && out_xfer) begin
                    main_d = cap;
                end else if (in_xfer) begin
                    skid_d  = cap;
                    state_d = ST_TWO;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (out_xfer) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // NOTE: handshake flags are registered from the next state so neither
    // in_ready nor out_valid has a combinational path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q.data;
    assign out_sel   = main_q.sel;
    assign out_err   = main_q.err;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Self-checking bench: three mux_nto1_pipe configurations driven with a shared handshake,
// compared every cycle against a queue-based FIFO model of capacity two.
module tb_mux_nto1_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic in_valid;
    logic out_ready;

    // A: WIDTH=32, NUM_IN=4
    logic [127:0] a_data;
    logic [1:0]   a_sel;
    logic         a_ir, a_ov, a_err;
    logic [31:0]  a_od;
    logic [1:0]   a_os;
    // B: WIDTH=8, NUM_IN=3 (select 3 is out of range)
    logic [23:0]  b_data;
    logic [1:0]   b_sel;
    logic         b_ir, b_ov, b_err;
    logic [7:0]   b_od;
    logic [1:0]   b_os;
    // C: WIDTH=1, NUM_IN=2
    logic [1:0]   c_data;
    logic [0:0]   c_sel;
    logic         c_ir, c_ov, c_err;
    logic [0:0]   c_od;
    logic [0:0]   c_os;

    mux_nto1_pipe #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_sel(a_sel), .in_valid(in_valid),
        .in_ready(a_ir), .out_data(a_od), .out_sel(a_os), .out_err(a_err),
        .out_valid(a_ov), .out_ready(out_ready));

    mux_nto1_pipe #(.WIDTH(8), .NUM_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_valid(in_valid),
        .in_ready(b_ir), .out_data(b_od), .out_sel(b_os), .out_err(b_err),
        .out_valid(b_ov), .out_ready(out_ready));

    mux_nto1_pipe #(.WIDTH(1), .NUM_IN(2), .SEL_W(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel), .in_valid(in_valid),
        .in_ready(c_ir), .out_data(c_od), .out_sel(c_os), .out_err(c_err),
        .out_valid(c_ov), .out_ready(out_ready));

`ifdef MUXN_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] d;
        logic [7:0]  s;
        logic        e;
    } exp_t;

    exp_t a_q[$];
    exp_t b_q[$];
    exp_t c_q[$];
    int   errors   = 0;
    int   checks   = 0;
    bit   started  = 1'b0;
    bit   force_b3 = 1'b0;

    localparam logic [127:0] WORDS = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic rdy;
        logic vld;
        rdy = started && (a_q.size() < 2);
        vld = (a_q.size() > 0);
        check("a_in_ready",  32'(a_ir), 32'(rdy));
        check("b_in_ready",  32'(b_ir), 32'(rdy));
        check("c_in_ready",  32'(c_ir), 32'(rdy));
        check("a_out_valid", 32'(a_ov), 32'(vld));
        check("b_out_valid", 32'(b_ov), 32'(vld));
        check("c_out_valid", 32'(c_ov), 32'(vld));
        if (vld) begin
            check("a_out_data", a_od,          a_q[0].d);
            check("a_out_sel",  32'(a_os),     32'(a_q[0].s));
            check("a_out_err",  32'(a_err),    32'(a_q[0].e));
            check("b_out_data", 32'(b_od),     b_q[0].d);
            check("b_out_sel",  32'(b_os),     32'(b_q[0].s));
            check("b_out_err",  32'(b_err),    32'(b_q[0].e));
            check("c_out_data", 32'(c_od),     c_q[0].d);
            check("c_out_sel",  32'(c_os),     32'(c_q[0].s));
            check("c_out_err",  32'(c_err),    32'(c_q[0].e));
        end
    endtask

    // One clock cycle: called at a falling edge, returns at the next falling edge.
    task automatic cycle(input logic vld, input logic ordy, input logic [127:0] ad, input logic [1:0] as);
        exp_t ea, eb, ec;
        bit   in_x, out_x;
        in_valid  = vld;
        out_ready = ordy;
        a_data    = ad;
        a_sel     = as;
        b_data    = 24'($urandom);
        b_sel     = force_b3 ? 2'd3 : 2'($urandom_range(0, 3));
        c_data    = 2'($urandom_range(0, 3));
        c_sel     = 1'($urandom_range(0, 1));
        #1;
        check_outputs();
        in_x  = vld && started && (a_q.size() < 2);
        out_x = ordy && (a_q.size() > 0);
        ea.d = a_data[a_sel*32 +: 32];
        ea.s = 8'(a_sel);
        ea.e = 1'b0;
        if (b_sel < 2'd3) begin
            eb.d = 32'(b_data[b_sel*8 +: 8]);
            eb.e = 1'b0;
        end else begin
            eb.d = RANGE_CHK ? 32'd0 : 32'(b_data[7:0]);
            eb.e = RANGE_CHK;
        end
        eb.s = 8'(b_sel);
        ec.d = 32'(c_data[c_sel]);
        ec.s = 8'(c_sel);
        ec.e = 1'b0;
        if (out_x) begin
            void'(a_q.pop_front());
            void'(b_q.pop_front());
            void'(c_q.pop_front());
        end
        if (in_x) begin
            a_q.push_back(ea);
            b_q.push_back(eb);
            c_q.push_back(ec);
        end
        started = 1'b1;
        @(negedge clk);
    endtask

    task automatic rand_cycle(input int pct_valid);
        cycle(($urandom_range(0, 99) < pct_valid), 1'($urandom_range(0, 1)),
              {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
    endtask

    task automatic check_reset_state(input string pfx);
        check({pfx, "_a_out_valid"}, 32'(a_ov), 32'd0);
        check({pfx, "_a_in_ready"},  32'(a_ir), 32'd0);
        check({pfx, "_a_out_data"},  a_od,      32'd0);
        check({pfx, "_a_out_sel"},   32'(a_os), 32'd0);
        check({pfx, "_a_out_err"},   32'(a_err), 32'd0);
        check({pfx, "_b_out_data"},  32'(b_od), 32'd0);
        check({pfx, "_b_out_err"},   32'(b_err), 32'd0);
        check({pfx, "_c_out_data"},  32'(c_od), 32'd0);
        check({pfx, "_c_out_valid"}, 32'(c_ov), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_data    = '0;
        a_sel     = '0;
        b_data    = '0;
        b_sel     = '0;
        c_data    = '0;
        c_sel     = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_state("por");
        rst_n = 1'b1;

        // in_ready stays low until the first edge after release
        cycle(1'b1, 1'b1, WORDS, 2'd0);

        // select sweep, back-to-back
        for (int s = 0; s < 4; s++) cycle(1'b1, 1'b1, WORDS, 2'(s));
        cycle(1'b0, 1'b1, WORDS, 2'd0);
        cycle(1'b0, 1'b1, WORDS, 2'd0);

        // backpressure: A and B absorbed, C refused until space frees
        cycle(1'b1, 1'b0, WORDS, 2'd1);
        cycle(1'b1, 1'b0, WORDS, 2'd2);
        cycle(1'b1, 1'b0, WORDS, 2'd3);
        cycle(1'b1, 1'b0, WORDS, 2'd3);
        cycle(1'b1, 1'b1, WORDS, 2'd3);
        cycle(1'b1, 1'b1, WORDS, 2'd3);
        cycle(1'b0, 1'b1, WORDS, 2'd0);
        cycle(1'b0, 1'b1, WORDS, 2'd0);

        // random traffic, mostly simultaneous in/out
        repeat (40) rand_cycle(85);

        // out-of-range select on the NUM_IN=3 instance
        force_b3 = 1'b1;
        repeat (4) cycle(1'b1, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 2'($urandom_range(0, 3)));
        force_b3 = 1'b0;
        cycle(1'b0, 1'b1, WORDS, 2'd0);
        cycle(1'b0, 1'b1, WORDS, 2'd0);

        // reset with both entries occupied
        cycle(1'b1, 1'b0, WORDS, 2'd1);
        cycle(1'b1, 1'b0, WORDS, 2'd2);
        #2 rst_n = 1'b0;
        #1;
        check_reset_state("mid");
        a_q.delete();
        b_q.delete();
        c_q.delete();
        started = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b1, WORDS, 2'd3);
        repeat (30) rand_cycle(70);
        repeat (3) cycle(1'b0, 1'b1, WORDS, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
